// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
//   Shared definitions for the multi-port register file.
//   - Default DATA_W / ADDR_W values for the register file and its interface.
//   - last_hit(): resolves write-port priority for one register address.
//     It returns {hit, port}, where port is the highest-index enabled write
//     port that targets the address. The storage array and the bypass path
//     both call it, so the two always agree on which port wins.
//   The function works on buses padded to MAX_WR ports of MAX_ADDR_W bits.
//   Callers zero-extend their addresses and tie unused enables low.
// ---------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int MAX_WR     = 4;
  localparam int MAX_ADDR_W = 16;
  localparam int PORT_W     = 2;

  typedef struct packed {
    logic              hit;
    logic [PORT_W-1:0] port;
  } hit_t;

  // Later ports overwrite earlier matches, so the highest index wins.
  function automatic hit_t last_hit(input logic [MAX_WR-1:0]            en,
                                    input logic [MAX_WR*MAX_ADDR_W-1:0] addrs,
                                    input logic [MAX_ADDR_W-1:0]        a);
    hit_t res;
    res = '0;
    for (int w = 0; w < MAX_WR; w++) begin
      if (en[w] && (addrs[w*MAX_ADDR_W +: MAX_ADDR_W] == a)) begin
        res.hit  = 1'b1;
        res.port = PORT_W'(w);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_multiport_if.sv
// ---------------------------------------------------------------------------
// reg_file_multiport_if
//   Bundles the register-file bus signals.
//   master: decode / writeback side. It drives the addresses, the write
//           strobes, the write data and the alloc request.
//   slave : the register file. It returns readData, readReady and
//           pendingCount.
//   Signals:
//     readReg      NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
//     readData     NUM_RD*DATA_W  read data (combinational)
//     readReady    NUM_RD         1 = addressed register not pending
//     writeEnable  NUM_WR         per-port write strobe
//     writeReg     NUM_WR*ADDR_W  write addresses
//     writeData    NUM_WR*DATA_W  write data
//     allocEnable  1              mark allocReg pending
//     allocReg     ADDR_W         register to mark pending
//     pendingCount ADDR_W+1       number of pending registers (registered)
// ---------------------------------------------------------------------------
interface reg_file_multiport_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);

  logic [NUM_RD*ADDR_W-1:0] readReg;
  logic [NUM_RD*DATA_W-1:0] readData;
  logic [NUM_RD-1:0]        readReady;
  logic [NUM_WR-1:0]        writeEnable;
  logic [NUM_WR*ADDR_W-1:0] writeReg;
  logic [NUM_WR*DATA_W-1:0] writeData;
  logic                     allocEnable;
  logic [ADDR_W-1:0]        allocReg;
  logic [ADDR_W:0]          pendingCount;

  modport master (
    output readReg, writeEnable, writeReg, writeData, allocEnable, allocReg,
    input  readData, readReady, pendingCount
  );

  modport slave (
    input  readReg, writeEnable, writeReg, writeData, allocEnable, allocReg,
    output readData, readReady, pendingCount
  );

endinterface

// File: rtl/reg_file_multiport_rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
//   Tracks one pending bit per register, plus a registered count of the
//   bits that are set.
//   Ports:
//     clk         clock
//     reset       synchronous, active-low reset
//     alloc_en_i  mark alloc_reg_i pending (the caller already drops reg 0
//                 when it is hard-wired to zero)
//     alloc_reg_i register to mark pending
//     clear_i     per-register clear (an enabled write to that register)
//     pending_o   current pending vector
//     count_o     popcount of pending_o, updated on the same edge
// ---------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_en_i,
  input  logic [ADDR_W-1:0]        alloc_reg_i,
  input  logic [(1<<ADDR_W)-1:0]   clear_i,
  output logic [(1<<ADDR_W)-1:0]   pending_o,
  output logic [ADDR_W:0]          count_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bit
      logic set_hit;
      assign set_hit = alloc_en_i && (alloc_reg_i == ADDR_W'(gi));
      // Alloc beats clear: a newer producer is still outstanding.
      assign pending_d[gi] = set_hit ? 1'b1
                           : (clear_i[gi] ? 1'b0 : pending_q[gi]);
    end
  endgenerate

  // Counting the next-state vector keeps the count in step with pending.
  always_comb begin
    count_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      count_d = count_d + CNT_W'(pending_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending_o = pending_q;
  assign count_o   = count_q;

endmodule

// File: rtl/reg_file_multiport.sv
// ---------------------------------------------------------------------------
// reg_file_multiport
//   Parametrised register file with NUM_RD combinational read ports,
//   NUM_WR write ports, and a pending scoreboard (alloc / writeback).
//   Parameters:
//     DATA_W, ADDR_W (DEPTH = 2**ADDR_W), NUM_RD (1..8), NUM_WR (1..4)
//     ZERO_REG  1: register 0 reads 0 and ignores writes/alloc
//   Ports:
//     clk    clock; all state updates on posedge
//     reset  synchronous, active-low reset
//     bus    reg_file_multiport_if.slave (read, write and alloc signals)
//   Optional feature:
//     RF_BYPASS_EN (macro) forwards same-cycle write data and readiness
//     to the read ports. When undefined, reads show stored state only.
// ---------------------------------------------------------------------------
module reg_file_multiport
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_file_multiport_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]            regs_q [DEPTH];
  logic [DATA_W-1:0]            regs_d [DEPTH];
  logic [DEPTH-1:0]             wr_hit;
  logic [DEPTH-1:0]             pending;
  logic                         alloc_ok;

  // Write ports padded to the package function's fixed shape.
  logic [MAX_WR-1:0]            wr_en_pad;
  logic [MAX_WR*MAX_ADDR_W-1:0] wr_addr_pad;
  logic [DATA_W-1:0]            wr_data_pad [MAX_WR];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_WR; gi++) begin : g_wpad
      if (gi < NUM_WR) begin : g_used
        assign wr_en_pad[gi] = bus.writeEnable[gi];
        assign wr_addr_pad[gi*MAX_ADDR_W +: MAX_ADDR_W] =
          MAX_ADDR_W'(bus.writeReg[gi*ADDR_W +: ADDR_W]);
        assign wr_data_pad[gi] = bus.writeData[gi*DATA_W +: DATA_W];
      end else begin : g_unused
        assign wr_en_pad[gi]                            = 1'b0;
        assign wr_addr_pad[gi*MAX_ADDR_W +: MAX_ADDR_W] = '0;
        assign wr_data_pad[gi]                          = '0;
      end
    end
  endgenerate

  // Next state of the array. wr_hit doubles as the scoreboard clear.
  always_comb begin
    hit_t lh;
    lh = '0;
    for (int r = 0; r < DEPTH; r++) begin
      lh        = last_hit(wr_en_pad, wr_addr_pad, MAX_ADDR_W'(r));
      wr_hit[r] = lh.hit;
      regs_d[r] = lh.hit ? wr_data_pad[lh.port] : regs_q[r];
      if ((ZERO_REG != 0) && (r == 0)) begin
        wr_hit[r] = 1'b0;
        regs_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Drop allocs to a hard-wired zero register, so it can never be pending.
  assign alloc_ok = bus.allocEnable &&
                    !((ZERO_REG != 0) && (bus.allocReg == '0));

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .alloc_en_i  (alloc_ok),
    .alloc_reg_i (bus.allocReg),
    .clear_i     (wr_hit),
    .pending_o   (pending),
    .count_o     (bus.pendingCount)
  );

  // Read muxes
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_data;
      logic              rd_ready;

      assign ra = bus.readReg[gi*ADDR_W +: ADDR_W];

      always_comb begin
`ifdef RF_BYPASS_EN
        hit_t blh;
`endif
        rd_data  = regs_q[ra];
        rd_ready = ~pending[ra];
`ifdef RF_BYPASS_EN
        // A same-cycle write means the value is here now. The register
        // stays unready only if a new producer is allocated in this cycle.
        blh = last_hit(wr_en_pad, wr_addr_pad, MAX_ADDR_W'(ra));
        if (blh.hit) begin
          rd_data  = wr_data_pad[blh.port];
          rd_ready = !(bus.allocEnable && (bus.allocReg == ra));
        end
`endif
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rd_data  = '0;
          rd_ready = 1'b1;
        end
      end

      assign bus.readData[gi*DATA_W +: DATA_W] = rd_data;
      assign bus.readReady[gi]                 = rd_ready;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_multiport.sv
// ---------------------------------------------------------------------------
// tb_reg_file_multiport
//   Directed testbench for reg_file_multiport (DATA_W=32, ADDR_W=5,
//   2 read ports, 2 write ports, ZERO_REG=1). Expected values are
//   hand-computed constants. Builds with and without RF_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_reg_file_multiport;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  reg_file_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();

  reg_file_multiport #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .ZERO_REG (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic clr_in();
    bus.writeEnable = '0;
    bus.writeReg    = '0;
    bus.writeData   = '0;
    bus.allocEnable = 1'b0;
    bus.allocReg    = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    bus.writeEnable[p]       = 1'b1;
    bus.writeReg[p*5 +: 5]   = a;
    bus.writeData[p*32 +: 32] = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    bus.readReg[p*5 +: 5] = a;
  endtask

  task automatic alloc(input logic [4:0] a);
    bus.allocEnable = 1'b1;
    bus.allocReg    = a;
  endtask

  // Returns 1 ns after the rising edge, clear of the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    bus.readReg = '0;
    clr_in();
    tick();
    tick();
    reset = 1'b1;

    // 1: state written, then reset (reset also wins over a same-cycle write/alloc)
    for (int i = 1; i < 6; i++) begin
      wr(0, 5'(i), $urandom());
      wr(1, 5'(i + 10), $urandom());
      tick();
    end
    clr_in();
    wr(0, 5'd1, 32'h1111_1111);
    wr(1, 5'd2, 32'h2222_2222);
    alloc(5'd6);
    tick();
    clr_in();
    rd(0, 5'd1);
    rd(1, 5'd6);
    #1;
    check("pre_reset_r1", bus.readData[31:0], 64'h1111_1111);
    check("pre_reset_pcount", bus.pendingCount, 64'd1);
    check("pre_reset_ready_r6", bus.readReady[1], 64'd0);
    reset = 1'b0;
    wr(0, 5'd1, 32'h3333_3333);
    alloc(5'd8);
    tick();
    reset = 1'b1;
    clr_in();
    rd(1, 5'd2);
    #1;
    check("reset_data_r1", bus.readData[31:0], 64'd0);
    check("reset_data_r2", bus.readData[63:32], 64'd0);
    check("reset_ready", bus.readReady, 64'b11);
    check("reset_pcount", bus.pendingCount, 64'd0);
    rd(0, 5'd8);
    rd(1, 5'd6);
    #1;
    check("reset_ready_r8_r6", bus.readReady, 64'b11);

    // 2: both write ports target r5, port 1 wins
    wr(0, 5'd5, 32'hAAAA_0000);
    wr(1, 5'd5, 32'h5555_FFFF);
    tick();
    clr_in();
    rd(0, 5'd5);
    #1;
    check("prio_r5", bus.readData[31:0], 64'h5555_FFFF);

    // 3: hard-wired zero register
    wr(0, 5'd0, 32'hDEAD_BEEF);
    alloc(5'd0);
    tick();
    clr_in();
    rd(0, 5'd0);
    #1;
    check("zero_data", bus.readData[31:0], 64'd0);
    check("zero_ready", bus.readReady[0], 64'd1);
    check("zero_pcount", bus.pendingCount, 64'd0);

    // 4: alloc r3, r7 and then write r3
    alloc(5'd3);
    tick();
    clr_in();
    rd(0, 5'd3);
    #1;
    check("alloc_r3_pcount", bus.pendingCount, 64'd1);
    check("alloc_r3_ready", bus.readReady[0], 64'd0);
    alloc(5'd7);
    tick();
    clr_in();
    #1;
    check("alloc_r7_pcount", bus.pendingCount, 64'd2);
    wr(0, 5'd3, 32'h0000_3333);
    tick();
    clr_in();
    rd(1, 5'd7);
    #1;
    check("wb_r3_pcount", bus.pendingCount, 64'd1);
    check("wb_r3_ready", bus.readReady[0], 64'd1);
    check("wb_r3_data", bus.readData[31:0], 64'h0000_3333);
    check("r7_still_pending", bus.readReady[1], 64'd0);

    // 5: alloc and write r9 in the same cycle
    alloc(5'd9);
    tick();
    clr_in();
    #1;
    check("alloc_r9_pcount", bus.pendingCount, 64'd2);
    alloc(5'd9);
    wr(1, 5'd9, 32'h9999_0009);
    tick();
    clr_in();
    rd(0, 5'd9);
    #1;
    check("alloc_wr_r9_pcount", bus.pendingCount, 64'd2);
    check("alloc_wr_r9_ready", bus.readReady[0], 64'd0);
    check("alloc_wr_r9_data", bus.readData[31:0], 64'h9999_0009);
    wr(0, 5'd7, 32'h7);
    wr(1, 5'd9, 32'h9);
    tick();
    clr_in();
    #1;
    check("clear_all_pcount", bus.pendingCount, 64'd0);

    // 6: write r4 and read it in the same cycle
    wr(0, 5'd4, 32'h1111_2222);
    tick();
    clr_in();
    wr(0, 5'd4, 32'h1234_5678);
    rd(0, 5'd4);
    #1;
`ifdef RF_BYPASS_EN
    check("same_cycle_r4", bus.readData[31:0], 64'h1234_5678);
`else
    check("same_cycle_r4", bus.readData[31:0], 64'h1111_2222);
`endif
    tick();
    clr_in();
    #1;
    check("next_cycle_r4", bus.readData[31:0], 64'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
